mic_array_framer: RTL and testbench
===================================

Name: mic_array_framer

Overview:
- Multi-channel output stage after the per-channel compensation FIR of the PDM decimation chain.
- Each sample-rate strobe captures one NCH-channel sample set into a FIFO.
- Serialises sets into fixed-length frames on a single IW-bit valid/ready stream for the array beamformer / host link.
- Generalises the single-mic, single-word decimator output to N channels with buffering, framing, backpressure and overflow accounting.

Parameters:
- NCH, 16: number of microphone channels per sample set (>=2).
- IW, 16: sample/output word width in bits (>=8).
- DEPTH, 32: FIFO depth in sample sets (power of two, >=2).
- FRAME_LEN, 256: sample sets per frame (>=1).

Ports:
- CLKDIVH2, in, 1: clock, decimated sample-rate domain.
- RST, in, 1: reset, asynchronous, active-high.
- enable, in, 1: capture enable, honoured at frame boundaries.
- in_valid, in, 1: one-cycle strobe, in_data holds a new sample set.
- in_data, in, NCH*IW: packed set, channel k at bits [k*IW +: IW], two's complement.
- out_data, out, IW: serial output word.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: sink accepts word when out_valid&&out_ready.
- out_sof, out, 1: qualifies first word of frame.
- out_eof, out, 1: qualifies last word of frame.
- level, out, $clog2(DEPTH+1): sets currently stored.
- overflow_cnt, out, 16: dropped sets, saturating at 0xFFFF.

Behaviour:
- Reset (async): out_data=0, out_valid=0, out_sof=0, out_eof=0, level=0, overflow_cnt=0; FIFO pointers, write set counter, read channel/set indices, frame_seq cleared; FSM=IDLE. Reset mid-frame discards all stored data; next frame restarts at seq 0.
- Write side:
  - wr_set_cnt counts accepted sets modulo FRAME_LEN.
  - Write is gated when enable=0 and wr_set_cnt==0; a frame in progress always completes.
  - Gated strobes are ignored and not counted.
  - Accept when in_valid && gate open && (!full || pop this cycle).
  - When full with no pop: set dropped whole, overflow_cnt+1 (saturating), wr_set_cnt unchanged.
- Pop occurs when the last channel word (k=NCH-1) of the head set is accepted.
- level updates on the edge of the write/pop: +1 write only, -1 pop only, unchanged both.
- Read FSM (outputs registered):
  - IDLE: out_valid=0. If FIFO non-empty: go HDR if HEADER_EN and set_idx==0, else DATA with k=0.
  - HDR: present header word, out_sof=1. On accept -> DATA, k=0.
  - DATA: present channel k of head set.
    - out_sof=1 iff k==0, set_idx==0 and no header.
    - out_eof=1 iff k==NCH-1 and set_idx==FRAME_LEN-1.
    - On accept: k+1. At k==NCH-1: pop, k=0, set_idx+1; at frame end set_idx=0 and frame_seq+1 (wraps).
    - Then stay DATA if a further set is stored (excluding popped), else IDLE.
- Stream rule: once out_valid=1, out_data/out_sof/out_eof hold stable until accepted. No gaps are inserted while data is available.
- Latency: set written at edge t gives its first word valid after edge t+1 (empty FIFO, IDLE).
- Throughput: one word per cycle with out_ready=1; the sustained in_valid rate must be <= 1/NCH (or 1/(NCH+1) with headers).

Optional Feature:
- MIC_FRAME_HEADER_EN defined: each frame is preceded by one header word = {4'hA, frame_seq[IW-5:0]}. The header carries out_sof; the frame is NCH*FRAME_LEN+1 words.
- Undefined: no header word; out_sof is on channel 0 of set 0; the frame is NCH*FRAME_LEN words; frame_seq is still maintained internally.

Test Plan (NCH=4, IW=16, DEPTH=4, FRAME_LEN=2, header off unless stated):
- Basic: enable=1, out_ready=1, strobe sets {1,2,3,4} then {5,6,7,8} 8 cycles apart -> words 1..8. sof on word 1, eof on word 8. First word valid one edge after the first write. level returns to 0.
- Backpressure: out_ready toggles 1/0 every cycle -> identical 8-word sequence; out_data stable across every stalled cycle; no word lost or duplicated.
- Overflow: out_ready=0, strobe 6 sets -> level=4, overflow_cnt=2. Release ready -> exactly sets 1..4 emitted, 2 frames, eof on words 8 and 16.
- Enable boundary: drop enable after the first set of a frame -> second set still captured, frame completes. Later strobes ignored; overflow_cnt unchanged.
- Header (MIC_FRAME_HEADER_EN): two frames -> first word 0xA000 with sof, second frame header 0xA001; 9 words per frame.
- Reset mid-frame: assert RST after word 3 of a frame -> all outputs 0 immediately. Next frame starts cleanly at channel 0 (header 0xA000 if enabled).

Source files
------------

// File: rtl/mic_array_framer.sv
// Multi-channel sample-set FIFO and frame serialiser for the mic array stream.
// Define MIC_FRAME_HEADER_EN to prefix each frame with a {4'hA, frame_seq} header word.
module mic_array_framer #(
    parameter int NCH       = 16,
    parameter int IW        = 16,
    parameter int DEPTH     = 32,
    parameter int FRAME_LEN = 256
) (
    input  logic                         CLKDIVH2,
    input  logic                         RST,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic [NCH*IW-1:0]            in_data,
    output logic [IW-1:0]                out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sof,
    output logic                         out_eof,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  overflow_cnt
);

`ifdef MIC_FRAME_HEADER_EN
    localparam logic HDR_EN = 1'b1;
`else
    localparam logic HDR_EN = 1'b0;
`endif

    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(NCH);
    localparam int SW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int LW = $clog2(DEPTH+1);
    localparam int QW = IW - 4;

    localparam logic [SW-1:0] LAST_SET = SW'(FRAME_LEN-1);
    localparam logic [KW-1:0] LAST_CH  = KW'(NCH-1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [IW-1:0] mem [DEPTH][NCH];

    logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
    logic [SW-1:0] wr_set_cnt, set_idx, set_n;
    logic [KW-1:0] k, k_n;
    logic [QW-1:0] frame_seq, seq_n;
    logic [1:0]    st, st_n;

    logic          gate_open, full, accept, pop, push, drop;
    logic          ov_n, sof_n, eof_n;
    logic [IW-1:0] od_n;

    assign gate_open = enable || (wr_set_cnt != '0);
    assign full      = (level == FULL_LVL);
    assign accept    = out_valid && out_ready;
    assign push      = in_valid && gate_open && (!full || pop);
    assign drop      = in_valid && gate_open && full && !pop;

    always_comb begin
        st_n  = st;
        k_n   = k;
        set_n = set_idx;
        seq_n = frame_seq;
        rd_n  = rd_ptr;
        pop   = 1'b0;
        case (st)
            S_IDLE: begin
                if (level != '0) begin
                    st_n = (HDR_EN && set_idx == '0) ? S_HDR : S_DATA;
                    k_n  = '0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    st_n = S_DATA;
                    k_n  = '0;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (k == LAST_CH) begin
                        pop  = 1'b1;
                        rd_n = rd_ptr + 1'b1;
                        k_n  = '0;
                        if (set_idx == LAST_SET) begin
                            set_n = '0;
                            seq_n = frame_seq + 1'b1;
                        end else begin
                            set_n = set_idx + 1'b1;
                        end
                        // Only sets already stored before this edge may follow back-to-back.
                        if (level > LW'(1))
                            st_n = (HDR_EN && set_n == '0) ? S_HDR : S_DATA;
                        else
                            st_n = S_IDLE;
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end
            default: st_n = S_IDLE;
        endcase
    end

    // Outputs reload only when the current word is gone, so a stalled word holds.
    always_comb begin
        ov_n  = out_valid;
        od_n  = out_data;
        sof_n = out_sof;
        eof_n = out_eof;
        if (!out_valid || out_ready) begin
            ov_n  = 1'b0;
            od_n  = '0;
            sof_n = 1'b0;
            eof_n = 1'b0;
            if (st_n == S_HDR) begin
                ov_n  = 1'b1;
                od_n  = {4'hA, seq_n};
                sof_n = 1'b1;
            end else if (st_n == S_DATA) begin
                ov_n  = 1'b1;
                od_n  = mem[rd_n][k_n];
                sof_n = !HDR_EN && (k_n == '0) && (set_n == '0);
                eof_n = (k_n == LAST_CH) && (set_n == LAST_SET);
            end
        end
    end

    always_ff @(posedge CLKDIVH2) begin
        if (push) begin
            for (int c = 0; c < NCH; c++)
                mem[wr_ptr][c] <= in_data[c*IW +: IW];
        end
    end

    always_ff @(posedge CLKDIVH2 or posedge RST) begin
        if (RST) begin
            wr_ptr       <= '0;
            wr_set_cnt   <= '0;
            level        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                wr_set_cnt <= (wr_set_cnt == LAST_SET) ? '0 : wr_set_cnt + 1'b1;
            end
            if (drop && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 16'd1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge CLKDIVH2 or posedge RST) begin
        if (RST) begin
            st        <= S_IDLE;
            k         <= '0;
            set_idx   <= '0;
            frame_seq <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            st        <= st_n;
            k         <= k_n;
            set_idx   <= set_n;
            frame_seq <= seq_n;
            rd_ptr    <= rd_n;
            out_valid <= ov_n;
            out_data  <= od_n;
            out_sof   <= sof_n;
            out_eof   <= eof_n;
        end
    end

endmodule

// File: tb/tb_mic_array_framer.sv
// Self-checking bench for mic_array_framer: queue-based stream model plus directed literals.
// Honours MIC_FRAME_HEADER_EN when defined for the whole build.
module tb_mic_array_framer;

    localparam int NCH = 4;
    localparam int IW  = 16;
    localparam int DEPTH = 4;
    localparam int FL  = 2;

`ifdef MIC_FRAME_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic              CLKDIVH2;
    logic              RST;
    logic              enable;
    logic              in_valid;
    logic [NCH*IW-1:0] in_data;
    logic [IW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;
    logic [2:0]        level;
    logic [15:0]       overflow_cnt;

    mic_array_framer #(
        .NCH(NCH), .IW(IW), .DEPTH(DEPTH), .FRAME_LEN(FL)
    ) dut (
        .CLKDIVH2    (CLKDIVH2),
        .RST         (RST),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sof     (out_sof),
        .out_eof     (out_eof),
        .level       (level),
        .overflow_cnt(overflow_cnt)
    );

    initial CLKDIVH2 = 1'b0;
    always #5 CLKDIVH2 = ~CLKDIVH2;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: stored sets, write-side frame count, drops, and stream position.
    logic [63:0] sq[$];
    int          m_wr, m_ov;
    int          p_k, p_set, p_seq;
    bit          hdr_done;
    logic [15:0] all_d[$];
    bit          all_sof[$];
    logic [15:0] dat_d[$];
    bit          dat_sof[$];
    bit          dat_eof[$];
    bit          pv_stall;
    logic [17:0] pv_word;

    function automatic logic [17:0] exp_word();
        logic [15:0] d;
        logic [63:0] s;
        if (HDR && p_k == 0 && p_set == 0 && !hdr_done)
            return {1'b1, 1'b0, 4'hA, 12'(p_seq)};
        s = sq[0];
        d = s[p_k*16 +: 16];
        return {(!HDR && p_k == 0 && p_set == 0), (p_k == NCH-1 && p_set == FL-1), d};
    endfunction

    always @(negedge CLKDIVH2) begin
        logic [17:0] ew;
        bit is_hdr;
        if (RST) begin
            sq.delete();
            m_wr = 0; m_ov = 0;
            p_k = 0; p_set = 0; p_seq = 0;
            hdr_done = 1'b0;
            pv_stall = 1'b0;
        end else begin
            chk("level", level, sq.size());
            chk("overflow_cnt", overflow_cnt, m_ov);
            if (pv_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_word", {out_sof, out_eof, out_data}, pv_word);
            end
            if (out_valid) begin
                chk("stored_when_valid", sq.size() != 0, 1);
                if (sq.size() != 0) begin
                    ew = exp_word();
                    chk("word", {out_sof, out_eof, out_data}, ew);
                    if (out_ready) begin
                        is_hdr = HDR && p_k == 0 && p_set == 0 && !hdr_done;
                        all_d.push_back(out_data);
                        all_sof.push_back(out_sof);
                        if (is_hdr) begin
                            hdr_done = 1'b1;
                        end else begin
                            dat_d.push_back(out_data);
                            dat_sof.push_back(out_sof);
                            dat_eof.push_back(out_eof);
                            if (p_k == NCH-1) begin
                                void'(sq.pop_front());
                                p_k = 0;
                                p_set++;
                                if (p_set == FL) begin
                                    p_set = 0;
                                    p_seq = (p_seq + 1) % 4096;
                                    hdr_done = 1'b0;
                                end
                            end else begin
                                p_k++;
                            end
                        end
                    end
                end
            end
            if (in_valid && (enable || m_wr != 0)) begin
                if (sq.size() < DEPTH) begin
                    sq.push_back(in_data);
                    m_wr = (m_wr + 1) % FL;
                end else if (m_ov < 65535) begin
                    m_ov++;
                end
            end
            pv_stall = out_valid && !out_ready;
            pv_word  = {out_sof, out_eof, out_data};
        end
    end

    function automatic logic [63:0] mk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic tick();
        @(posedge CLKDIVH2);
        #1;
    endtask

    task automatic strobe(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sq.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_ok", (sq.size() == 0 && !out_valid), 1);
    endtask

    task automatic chk_run(input string name, input int b, input int first, input int cnt);
        chk({name, "_count"}, dat_d.size() - b, cnt);
        for (int i = 0; i < cnt && b + i < dat_d.size(); i++)
            chk({name, "_data"}, dat_d[b+i], first + i);
    endtask

    initial begin
        int b, ab, n;
        RST = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_eof", out_eof, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow_cnt, 0);
        RST = 1'b0;
        tick();

        // Basic two-set frame and first-word latency.
        enable = 1'b1; out_ready = 1'b1;
        b = dat_d.size();
        strobe(mk(1, 2, 3, 4));
        chk("lat_edge_t", out_valid, 0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, HDR ? 16'hA000 : 16'h0001);
        chk("lat_sof", out_sof, 1);
        repeat (6) tick();
        strobe(mk(5, 6, 7, 8));
        wait_idle(50);
        chk_run("basic", b, 1, 8);
        chk("basic_sof", dat_sof[b], !HDR);
        chk("basic_eof", dat_eof[b+7], 1);
        chk("basic_level", level, 0);

        // Backpressure: ready toggles every cycle.
        b = dat_d.size();
        for (int c = 0; c < 40; c++) begin
            in_valid  = (c == 0 || c == 10);
            in_data   = (c == 0) ? mk(1, 2, 3, 4) : mk(5, 6, 7, 8);
            out_ready = c[0];
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle(50);
        chk_run("bp", b, 1, 8);
        chk("bp_eof", dat_eof[b+7], 1);

        // Overflow: six sets into a four-deep FIFO with the sink stalled.
        out_ready = 1'b0;
        b = dat_d.size();
        ab = all_d.size();
        for (int i = 0; i < 6; i++)
            strobe(mk(4*i+1, 4*i+2, 4*i+3, 4*i+4));
        tick();
        chk("ovf_level", level, 4);
        chk("ovf_cnt", overflow_cnt, 2);
        out_ready = 1'b1;
        wait_idle(100);
        chk_run("ovf", b, 1, 16);
        chk("ovf_eof1", dat_eof[b+7], 1);
        chk("ovf_eof2", dat_eof[b+15], 1);
        chk("ovf_words", all_d.size() - ab, HDR ? 18 : 16);

        // Enable dropped mid-frame: the frame still completes, later strobes ignored.
        b = dat_d.size();
        strobe(mk(17, 18, 19, 20));
        enable = 1'b0;
        strobe(mk(21, 22, 23, 24));
        repeat (12) tick();
        strobe(mk(99, 99, 99, 99));
        strobe(mk(98, 98, 98, 98));
        wait_idle(50);
        chk_run("enable", b, 17, 8);
        chk("enable_ovf", overflow_cnt, 2);

        // Reset after the third word of a frame.
        enable = 1'b1; out_ready = 1'b0;
        strobe(mk(49, 50, 51, 52));
        strobe(mk(53, 54, 55, 56));
        ab = all_d.size();
        out_ready = 1'b1;
        n = 0;
        while (all_d.size() - ab < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_words", all_d.size() - ab, 3);
        out_ready = 1'b0;
        RST = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_sof", out_sof, 0);
        chk("mid_rst_eof", out_eof, 0);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ovf", overflow_cnt, 0);
        tick(); tick();
        RST = 1'b0;
        tick();
        out_ready = 1'b1;
        ab = all_d.size();
        b = dat_d.size();
        strobe(mk(65, 66, 67, 68));
        wait_idle(50);
        chk("post_rst_count", all_d.size() - ab, HDR ? 5 : 4);
        if (all_d.size() > ab) begin
            chk("post_rst_first", all_d[ab], HDR ? 16'hA000 : 16'h0041);
            chk("post_rst_sof", all_sof[ab], 1);
        end
        chk_run("post_rst", b, 65, 4);

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, NCH + 1) == 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
